logo_motion_ctrl: RTL and testbench

LOGO_MOTION_CTRL -- requirements
Module: logo_motion_ctrl

---
 rtl/vga_pkg.sv | 28 ++
 rtl/logo_motion_ctrl_if.sv | 26 ++
 rtl/axis_bounce.sv | 48 ++++
 rtl/logo_motion_ctrl.sv | 109 ++++++++++
 tb/tb_logo_motion_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, logo FSM state encoding and the move-interval helper
// used by the logo motion controller.
package vga_pkg;

  localparam int CNT_W        = 10;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_MOVE_X     = 2'd2,
    ST_MOVE_Y     = 2'd3
  } state_t;

  // sel 0..3 looks at 3, 2, 1 or 0 low bits of the frame counter.
  function automatic logic move_due(input logic [2:0] cnt, input logic [1:0] sel);
    logic due;
    case (sel)
      2'd0:    due = &cnt;
      2'd1:    due = &cnt[1:0];
      2'd2:    due = cnt[0];
      default: due = 1'b1;
    endcase
    return due;
  endfunction

endpackage

// File: rtl/logo_motion_ctrl_if.sv
// Raster counters and controls into the logo controller, position/direction/bounce out.
// The master side is the VGA timing block plus control logic; the slave side is the controller.
interface logo_motion_ctrl_if;
  import vga_pkg::*;

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             enable;
  logic [1:0]       speed_sel;
  logic [CNT_W-1:0] logo_x;
  logic [CNT_W-1:0] logo_y;
  logic             dir_x;
  logic             dir_y;
  logic             bounce;

  modport master (
    output h_cnt, v_cnt, enable, speed_sel,
    input  logo_x, logo_y, dir_x, dir_y, bounce
  );

  modport slave (
    input  h_cnt, v_cnt, enable, speed_sel,
    output logo_x, logo_y, dir_x, dir_y, bounce
  );

endinterface

// File: rtl/axis_bounce.sv
// One axis of the bouncing-logo step: next position, next direction and whether it reversed.
// Arithmetic is one bit wider than the position so pos+STEP never wraps.
module axis_bounce
  import vga_pkg::*;
#(
  parameter int MAX  = 576,
  parameter int STEP = 2
) (
  input  logic [CNT_W-1:0] i_pos,
  input  logic             i_dir,
  output logic [CNT_W-1:0] o_pos,
  output logic             o_dir,
  output logic             o_flip
);

  localparam logic [CNT_W:0] STEP_W = STEP[CNT_W:0];
  localparam logic [CNT_W:0] MAX_W  = MAX[CNT_W:0];

  logic [CNT_W:0] w_pos_ext;
  logic [CNT_W:0] w_sum;

  assign w_pos_ext = {1'b0, i_pos};
  assign w_sum     = w_pos_ext + STEP_W;

  always_comb begin
    o_pos  = i_pos;
    o_dir  = i_dir;
    o_flip = 1'b0;
    if (i_dir) begin
      if (w_sum >= MAX_W) begin
        o_pos  = MAX_W[CNT_W-1:0];
        o_dir  = 1'b0;
        o_flip = 1'b1;
      end else begin
        o_pos = w_sum[CNT_W-1:0];
      end
    end else begin
      if (w_pos_ext <= STEP_W) begin
        o_pos  = '0;
        o_dir  = 1'b1;
        o_flip = 1'b1;
      end else begin
        o_pos = i_pos - STEP_W[CNT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/logo_motion_ctrl.sv
// Bouncing-logo position controller: moves the logo once every 1/2/4/8 frames during
// vertical blanking, X then Y on consecutive cycles, pulsing bounce on each reversal.
module logo_motion_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int LOGO_W   = 64,
  parameter int LOGO_H   = 32,
  parameter int STEP     = 2,
  parameter int X_INIT   = 0,
  parameter int Y_INIT   = 0
) (
  input logic             pclk,
  input logic             rst_n,
  logo_motion_ctrl_if.slave bus
);

  localparam int X_MAX = H_ACTIVE - LOGO_W;
  localparam int Y_MAX = V_ACTIVE - LOGO_H;

  localparam logic [CNT_W-1:0] X_INIT_W   = X_INIT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] Y_INIT_W   = Y_INIT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] V_ACTIVE_W = V_ACTIVE[CNT_W-1:0];

  state_t           r_state;
  logic [2:0]       r_frame_cnt;
  logic [CNT_W-1:0] r_logo_x;
  logic [CNT_W-1:0] r_logo_y;
  logic             r_dir_x;
  logic             r_dir_y;
  logic             r_bounce;

  logic             w_frame_tick;
  logic             w_move_start;
  logic [CNT_W-1:0] w_x_next;
  logic [CNT_W-1:0] w_y_next;
  logic             w_dir_x_next;
  logic             w_dir_y_next;
  logic             w_flip_x;
  logic             w_flip_y;

  // First pixel of the first blanking line: one cycle per frame.
  assign w_frame_tick = (bus.h_cnt == '0) && (bus.v_cnt == V_ACTIVE_W);
  assign w_move_start = w_frame_tick && bus.enable && move_due(r_frame_cnt, bus.speed_sel);

  axis_bounce #(.MAX(X_MAX), .STEP(STEP)) u_axis_x (
    .i_pos  (r_logo_x),
    .i_dir  (r_dir_x),
    .o_pos  (w_x_next),
    .o_dir  (w_dir_x_next),
    .o_flip (w_flip_x)
  );

  axis_bounce #(.MAX(Y_MAX), .STEP(STEP)) u_axis_y (
    .i_pos  (r_logo_y),
    .i_dir  (r_dir_y),
    .o_pos  (w_y_next),
    .o_dir  (w_dir_y_next),
    .o_flip (w_flip_y)
  );

  // Once MOVE_X starts it always runs through MOVE_Y, whatever enable does.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_frame_cnt <= 3'd0;
      r_logo_x    <= X_INIT_W;
      r_logo_y    <= Y_INIT_W;
      r_dir_x     <= 1'b1;
      r_dir_y     <= 1'b1;
      r_bounce    <= 1'b0;
    end else begin
      r_bounce <= 1'b0;
      if (w_frame_tick && bus.enable) begin
        r_frame_cnt <= r_frame_cnt + 3'd1;
      end
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_WAIT_FRAME;
        end
        ST_WAIT_FRAME: begin
          if (w_move_start) begin
            r_state <= ST_MOVE_X;
          end
        end
        ST_MOVE_X: begin
          r_logo_x <= w_x_next;
          r_dir_x  <= w_dir_x_next;
          r_bounce <= w_flip_x;
          r_state  <= ST_MOVE_Y;
        end
        ST_MOVE_Y: begin
          r_logo_y <= w_y_next;
          r_dir_y  <= w_dir_y_next;
          r_bounce <= w_flip_y;
          r_state  <= ST_WAIT_FRAME;
        end
      endcase
    end
  end

  assign bus.logo_x = r_logo_x;
  assign bus.logo_y = r_logo_y;
  assign bus.dir_x  = r_dir_x;
  assign bus.dir_y  = r_dir_y;
  assign bus.bounce = r_bounce;

endmodule

// File: tb/tb_logo_motion_ctrl.sv
// Self-checking bench for logo_motion_ctrl: four instances with different start points,
// a reference model with scoreboard for the main instance, directed bounce/reset checks.
module tb_logo_motion_ctrl;
  import vga_pkg::*;

  localparam int STEP = 2;

  logic       pclk = 1'b0;
  logic       rst0, rst1, rst2, rst3;
  logic [9:0] hCnt, vCnt;
  logic       enable;
  logic [1:0] speedSel;

  always #5 pclk = ~pclk;

  logo_motion_ctrl_if if0 ();
  logo_motion_ctrl_if if1 ();
  logo_motion_ctrl_if if2 ();
  logo_motion_ctrl_if if3 ();

  assign if0.h_cnt = hCnt;  assign if0.v_cnt = vCnt;
  assign if0.enable = enable;  assign if0.speed_sel = speedSel;
  assign if1.h_cnt = hCnt;  assign if1.v_cnt = vCnt;
  assign if1.enable = enable;  assign if1.speed_sel = speedSel;
  assign if2.h_cnt = hCnt;  assign if2.v_cnt = vCnt;
  assign if2.enable = enable;  assign if2.speed_sel = speedSel;
  assign if3.h_cnt = hCnt;  assign if3.v_cnt = vCnt;
  assign if3.enable = enable;  assign if3.speed_sel = speedSel;

  logo_motion_ctrl u0 (.pclk(pclk), .rst_n(rst0), .bus(if0.slave));
  logo_motion_ctrl #(.X_INIT(575)) u1 (.pclk(pclk), .rst_n(rst1), .bus(if1.slave));
  logo_motion_ctrl #(.X_INIT(576), .Y_INIT(448)) u2 (.pclk(pclk), .rst_n(rst2), .bus(if2.slave));
  logo_motion_ctrl #(.H_ACTIVE(16), .V_ACTIVE(12), .LOGO_W(3), .LOGO_H(2), .X_INIT(1))
    u3 (.pclk(pclk), .rst_n(rst3), .bus(if3.slave));

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       dx;
    logic       dy;
  } exp_t;

  exp_t       sbQueue[$];
  int         testsRun = 0;
  int         testsFailed = 0;
  int         mX, mY, mCnt;
  bit         mDx, mDy, sbOn;
  logic [3:0] bh [4];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic modelAxis(input int pos, input bit dir, input int maxv,
                           output int npos, output bit ndir);
    if (dir) begin
      if (pos + STEP >= maxv) begin npos = maxv; ndir = 1'b0; end
      else begin npos = pos + STEP; ndir = 1'b1; end
    end else begin
      if (pos <= STEP) begin npos = 0; ndir = 1'b1; end
      else begin npos = pos - STEP; ndir = 1'b0; end
    end
  endtask

  task automatic modelReset();
    mX = 0; mY = 0; mDx = 1'b1; mDy = 1'b1; mCnt = 0;
    sbQueue.delete();
  endtask

  // One frame: a frame_tick cycle then four blanking cycles, recording bounce per cycle.
  task automatic applyStimulus(input int vact, input bit dropEn);
    bit   due;
    int   nx, ny;
    bit   ndx, ndy;
    exp_t e;
    exp_t got;
    if (sbOn) begin
      case (speedSel)
        2'd0:    due = (mCnt % 8) == 7;
        2'd1:    due = (mCnt % 4) == 3;
        2'd2:    due = (mCnt % 2) == 1;
        default: due = 1'b1;
      endcase
      due = due && enable;
      if (enable) mCnt = (mCnt + 1) % 8;
      if (due) begin
        modelAxis(mX, mDx, 576, nx, ndx);
        modelAxis(mY, mDy, 448, ny, ndy);
        mX = nx; mDx = ndx; mY = ny; mDy = ndy;
      end
      e.x = 10'(mX); e.y = 10'(mY); e.dx = mDx; e.dy = mDy;
      sbQueue.push_back(e);
    end
    hCnt = 10'd0; vCnt = 10'(vact);
    step(1);
    hCnt = 10'd1; vCnt = 10'd0;
    if (dropEn) enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bh[0][k] = if0.bounce; bh[1][k] = if1.bounce;
      bh[2][k] = if2.bounce; bh[3][k] = if3.bounce;
      step(1);
    end
    if (sbOn) begin
      got = {if0.logo_x, if0.logo_y, if0.dir_x, if0.dir_y};
      testsRun++;
      if (sbQueue.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL scoreboard: queue empty, got x=%0d y=%0d", if0.logo_x, if0.logo_y);
      end else begin
        e = sbQueue.pop_front();
        if (got !== e) begin
          testsFailed++;
          $display("[TB] FAIL scoreboard: got x=%0d y=%0d dx=%0b dy=%0b, expected x=%0d y=%0d dx=%0b dy=%0b",
                   got.x, got.y, got.dx, got.dy, e.x, e.y, e.dx, e.dy);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst0 = 0; rst1 = 0; rst2 = 0; rst3 = 0;
    enable = 1'b1; speedSel = 2'd3; hCnt = 10'd1; vCnt = 10'd0;
    sbOn = 1'b0;
    step(2);
    testsRun++;
    if ({if0.logo_x, if0.logo_y, if0.dir_x, if0.dir_y, if0.bounce} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL reset_u0: got x=%0d y=%0d dx=%0b dy=%0b b=%0b, expected 0 0 1 1 0",
               if0.logo_x, if0.logo_y, if0.dir_x, if0.dir_y, if0.bounce);
    end
    testsRun++;
    if (if1.logo_x !== 10'd575 || if3.logo_x !== 10'd1 || if2.logo_y !== 10'd448) begin
      testsFailed++;
      $display("[TB] FAIL reset_init: got u1.x=%0d u3.x=%0d u2.y=%0d, expected 575 1 448",
               if1.logo_x, if3.logo_x, if2.logo_y);
    end
  endtask

  task automatic test_basic_motion();
    modelReset();
    sbOn = 1'b1;
    rst0 = 1'b1;
    step(2);
    applyStimulus(480, 1'b0);
    testsRun++;
    if (if0.logo_x !== 10'd2 || if0.logo_y !== 10'd2) begin
      testsFailed++;
      $display("[TB] FAIL one_frame: got %0d,%0d expected 2,2", if0.logo_x, if0.logo_y);
    end
    for (int f = 0; f < 4; f++) applyStimulus(480, 1'b0);
    testsRun++;
    if (if0.logo_x !== 10'd10 || if0.logo_y !== 10'd10) begin
      testsFailed++;
      $display("[TB] FAIL five_frames: got %0d,%0d expected 10,10", if0.logo_x, if0.logo_y);
    end
  endtask

  task automatic test_speed_sel();
    int         moves;
    logic [9:0] prevX;
    moves = 0;
    speedSel = 2'd0;
    for (int f = 0; f < 16; f++) begin
      prevX = if0.logo_x;
      applyStimulus(480, 1'b0);
      if (if0.logo_x != prevX) moves++;
    end
    testsRun++;
    if (moves != 2 || if0.logo_x !== 10'd14) begin
      testsFailed++;
      $display("[TB] FAIL speed_sel0: got %0d moves x=%0d, expected 2 moves x=14", moves, if0.logo_x);
    end
  endtask

  task automatic test_enable_hold();
    enable = 1'b0;
    for (int f = 0; f < 3; f++) applyStimulus(480, 1'b0);
    testsRun++;
    if (if0.logo_x !== 10'd14 || if0.logo_y !== 10'd14) begin
      testsFailed++;
      $display("[TB] FAIL enable_hold: got %0d,%0d expected 14,14", if0.logo_x, if0.logo_y);
    end
    enable = 1'b1;
    for (int f = 0; f < 3; f++) applyStimulus(480, 1'b0);
    testsRun++;
    if (if0.logo_x !== 10'd16) begin
      testsFailed++;
      $display("[TB] FAIL counter_held: got x=%0d expected 16", if0.logo_x);
    end
  endtask

  task automatic test_enable_drop_mid_move();
    speedSel = 2'd3;
    applyStimulus(480, 1'b1);
    enable = 1'b1;
    testsRun++;
    if (if0.logo_x !== 10'd18 || if0.logo_y !== 10'd18) begin
      testsFailed++;
      $display("[TB] FAIL enable_drop: got %0d,%0d expected 18,18", if0.logo_x, if0.logo_y);
    end
  endtask

  task automatic test_reset_mid_move();
    sbOn = 1'b0;
    applyStimulus(480, 1'b0);
    hCnt = 10'd0; vCnt = 10'd480;
    step(1);
    hCnt = 10'd1; vCnt = 10'd0;
    rst0 = 1'b0;
    #1;
    testsRun++;
    if ({if0.logo_x, if0.logo_y, if0.dir_x, if0.dir_y, if0.bounce} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_move: got x=%0d y=%0d dx=%0b dy=%0b, expected 0 0 1 1",
               if0.logo_x, if0.logo_y, if0.dir_x, if0.dir_y);
    end
    step(2);
    rst0 = 1'b1;
    step(3);
    testsRun++;
    if (if0.logo_x !== 10'd0 || if0.logo_y !== 10'd0) begin
      testsFailed++;
      $display("[TB] FAIL no_partial: got %0d,%0d expected 0,0", if0.logo_x, if0.logo_y);
    end
    modelReset();
    sbOn = 1'b1;
    applyStimulus(480, 1'b0);
    testsRun++;
    if (if0.logo_x !== 10'd2 || if0.logo_y !== 10'd2) begin
      testsFailed++;
      $display("[TB] FAIL resume: got %0d,%0d expected 2,2", if0.logo_x, if0.logo_y);
    end
    sbOn = 1'b0;
    rst0 = 1'b0;
  endtask

  task automatic test_right_bounce();
    rst1 = 1'b1;
    step(2);
    applyStimulus(480, 1'b0);
    testsRun++;
    if (if1.logo_x !== 10'd576 || if1.dir_x !== 1'b0 || bh[1] !== 4'b0010) begin
      testsFailed++;
      $display("[TB] FAIL right_edge: got x=%0d dx=%0b bounce=%b, expected 576 0 0010",
               if1.logo_x, if1.dir_x, bh[1]);
    end
    applyStimulus(480, 1'b0);
    testsRun++;
    if (if1.logo_x !== 10'd574 || if1.dir_x !== 1'b0 || bh[1] !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL right_return: got x=%0d dx=%0b bounce=%b, expected 574 0 0000",
               if1.logo_x, if1.dir_x, bh[1]);
    end
    rst1 = 1'b0;
  endtask

  task automatic test_corner();
    rst2 = 1'b1;
    step(2);
    applyStimulus(480, 1'b0);
    testsRun++;
    if ({if2.logo_x, if2.logo_y, if2.dir_x, if2.dir_y} !== {10'd576, 10'd448, 1'b0, 1'b0} || bh[2] !== 4'b0110) begin
      testsFailed++;
      $display("[TB] FAIL corner: got x=%0d y=%0d dx=%0b dy=%0b bounce=%b, expected 576 448 0 0 0110",
               if2.logo_x, if2.logo_y, if2.dir_x, if2.dir_y, bh[2]);
    end
    applyStimulus(480, 1'b0);
    testsRun++;
    if (if2.logo_x !== 10'd574 || if2.logo_y !== 10'd446 || bh[2] !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL corner_after: got x=%0d y=%0d bounce=%b, expected 574 446 0000",
               if2.logo_x, if2.logo_y, bh[2]);
    end
    rst2 = 1'b0;
  endtask

  task automatic test_left_bounce();
    rst3 = 1'b1;
    step(2);
    for (int f = 0; f < 6; f++) applyStimulus(12, 1'b0);
    testsRun++;
    if (if3.logo_x !== 10'd13 || if3.dir_x !== 1'b0 || bh[3] !== 4'b0010) begin
      testsFailed++;
      $display("[TB] FAIL small_right: got x=%0d dx=%0b bounce=%b, expected 13 0 0010",
               if3.logo_x, if3.dir_x, bh[3]);
    end
    for (int f = 0; f < 6; f++) applyStimulus(12, 1'b0);
    testsRun++;
    if (if3.logo_x !== 10'd1 || if3.dir_x !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL small_at_one: got x=%0d dx=%0b, expected 1 0", if3.logo_x, if3.dir_x);
    end
    applyStimulus(12, 1'b0);
    testsRun++;
    if (if3.logo_x !== 10'd0 || if3.dir_x !== 1'b1 || if3.logo_y !== 10'd6 || bh[3] !== 4'b0010) begin
      testsFailed++;
      $display("[TB] FAIL left_edge: got x=%0d dx=%0b y=%0d bounce=%b, expected 0 1 6 0010",
               if3.logo_x, if3.dir_x, if3.logo_y, bh[3]);
    end
    rst3 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_motion();
    test_speed_sel();
    test_enable_hold();
    test_enable_drop_mid_move();
    test_reset_mid_move();
    test_right_bounce();
    test_corner();
    test_left_bounce();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
